pe_psum_accum: RTL and testbench
================================

Name: pe_psum_accum

Overview:
- Sits directly below the bottom PE of each systolic column and consumes the 48-bit PE output stream.
- Accumulates partial sums over a programmable number of K-passes into a small per-column output buffer.
- At the end, drains the buffer with arithmetic right-shift and saturation, over a valid/ready interface to the output writer.
- Honours the PE's precision mode: one 48-bit lane in 16-bit mode, two independent 24-bit lanes in 8-bit mode (low lane in bits [23:0], high lane in bits [47:24]).

Parameters:
- PE_OUT_WIDTH, 48, width of the incoming PE result word.
- ACC_WIDTH, 64, accumulator width per entry; in 8-bit mode it splits into two ACC_WIDTH/2 lanes.
- OUT_WIDTH, 16, output word width; in 8-bit mode it holds two packed OUT_WIDTH/2 lanes.
- DEPTH, 16, number of accumulator entries (output addresses).
- ADDR_W, $clog2(DEPTH), entry address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; latches cfg_* and choose_8bit, then begins accumulation.
- choose_8bit  in  1  0 = 16-bit mode (single lane), 1 = 8-bit mode (dual lane).
- cfg_num_out  in  ADDR_W+1  entries per pass, 1..DEPTH (0 treated as 1).
- cfg_acc_len  in  16  passes to accumulate (0 treated as 1).
- cfg_shift  in  6  arithmetic right-shift applied at drain.
- in_valid  in  1  PE result beat valid.
- in_ready  out  1  high only in ACCUM.
- in_data  in  PE_OUT_WIDTH  PE output word.
- in_addr  in  ADDR_W  target entry for this beat.
- out_valid  out  1  drained word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_WIDTH  shifted, saturated result.
- out_addr  out  ADDR_W  entry index of out_data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last drained word is accepted.

Behaviour:
- Reset: state IDLE; in_ready=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0. Buffer contents are not cleared.
- Buffer: flop array, so read-modify-write completes in one cycle. Back-to-back beats to the same address are legal and hazard-free.
- FSM: IDLE -> ACCUM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - cfg_start latches configuration and zeroes pass_cnt; next state ACCUM.
  - in_valid is ignored.
- ACCUM:
  - Each accepted beat (in_valid & in_ready) writes sext(in_data) to the entry if pass_cnt==0; otherwise it adds sext(in_data) to the entry.
  - 8-bit mode: each 24-bit lane is sign-extended and added into its own ACC_WIDTH/2 lane. No carry crosses lanes; lane overflow wraps.
  - Accepting in_addr == cfg_num_out-1 ends a pass and increments pass_cnt.
  - When the final pass ends, next state is DRAIN.
  - in_addr >= cfg_num_out: beat is dropped, no pass effect.
- DRAIN:
  - Entries 0..cfg_num_out-1 are presented in order.
  - First out_valid asserts on the cycle after entering DRAIN. Sustains 1 word/cycle while out_ready=1.
  - While out_valid & !out_ready, out_data and out_addr hold stable.
  - Per lane: value >>> cfg_shift (arithmetic), then saturate.
    - 16-bit mode: saturate to signed OUT_WIDTH.
    - 8-bit mode: saturate each lane to signed OUT_WIDTH/2, packed {hi, lo}.
  - After the last word is accepted: state DONE, out_valid=0.
- DONE: done=1 for one cycle, then IDLE.
- cfg_start while busy: ignored.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values. The next job's first pass overwrites stale entries.

Optional Feature:
- Macro: PSUM_ROUND_EN.
- Defined: round-half-up at drain. When cfg_shift>0, add 1<<(cfg_shift-1) (in full accumulator width) before the shift, then saturate.
- Undefined: plain truncating arithmetic shift.

Test Plan:
- 16-bit mode, num_out=1, acc_len=3, shift=0, inputs 100, -30, 5 at addr 0 -> single out_data=0x004B, out_addr=0, then done pulse one cycle after acceptance.
- 8-bit mode, num_out=2, acc_len=2:
  - addr0 lanes lo=10, hi=-4 in both passes -> out_data=0xF814.
  - addr1 lo=200, hi=0 in both passes -> lo saturates, out_data=0x007F.
- 16-bit saturation, num_out=2, acc_len=1: addr0=40000, addr1=-40000 -> 0x7FFF then 0x8000.
- Shift, acc_len=1, shift=1:
  - value 7 -> 4 with PSUM_ROUND_EN, 3 without.
  - value -7 -> -3 with PSUM_ROUND_EN, -4 without.
- Backpressure: num_out=4, out_ready low for 5 cycles mid-drain -> out_data/out_addr stable, all four words delivered in order 0..3, exactly one done.
- Reset asserted in ACCUM after 2 beats -> next cycle busy=0, in_ready=0, out_valid=0. Then a new job with acc_len=1, value 9 -> out_data=9 (no stale sum).

Source files
------------

// File: rtl/pe_psum_accum.sv
// rtl/pe_psum_accum.sv - per-column partial-sum accumulator with shift/saturate drain
//
// Collects PE result beats into a DEPTH-entry accumulator buffer over cfg_acc_len
// passes, then drains entries 0..num_out-1 through an arithmetic right shift and
// saturation. In 8-bit mode every word carries two independent signed lanes.
//
// Optional feature: define PSUM_ROUND_EN for round-half-up before the drain shift;
// without it the shift truncates toward minus infinity.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cfg_start             one-cycle pulse in IDLE: latch cfg_* / choose_8bit, start job
//   choose_8bit           0 = one 48-bit lane, 1 = two 24-bit lanes
//   cfg_num_out           entries per pass (0 -> 1, clamped to DEPTH)
//   cfg_acc_len           passes to accumulate (0 -> 1)
//   cfg_shift             arithmetic right shift applied at drain
//   in_valid/in_ready     PE beat handshake; in_ready high only while accumulating
//   in_data, in_addr      PE result word and its target entry
//   out_valid/out_ready   drained word handshake
//   out_data, out_addr    shifted, saturated word and its entry index
//   busy                  high whenever not IDLE
//   done                  one-cycle pulse after the last drained word is accepted

module pe_psum_accum #(
  parameter int PE_OUT_WIDTH = 48,
  parameter int ACC_WIDTH    = 64,
  parameter int OUT_WIDTH    = 16,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_start,
  input  logic                    choose_8bit,
  input  logic [ADDR_W:0]         cfg_num_out,
  input  logic [15:0]             cfg_acc_len,
  input  logic [5:0]              cfg_shift,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PE_OUT_WIDTH-1:0] in_data,
  input  logic [ADDR_W-1:0]       in_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    busy,
  output logic                    done
);

  localparam int PL = PE_OUT_WIDTH / 2;
  localparam int AL = ACC_WIDTH / 2;
  localparam int OL = OUT_WIDTH / 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic                 mode8;
  logic [ADDR_W:0]      num_out;
  logic [15:0]          acc_len;
  logic [5:0]           shift;
  logic [15:0]          pass_cnt;
  logic [ADDR_W:0]      issue_cnt;
  logic [ACC_WIDTH-1:0] acc_mem [DEPTH];

  logic [ADDR_W:0]      cfg_num_eff;
  logic [15:0]          cfg_len_eff;
  logic                 beat_ok;
  logic                 pass_end;
  logic                 last_pass;
  logic                 out_last;
  logic [ACC_WIDTH-1:0] in_ext;
  logic [ACC_WIDTH-1:0] acc_old;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [ADDR_W-1:0]    rd_idx;
  logic [ACC_WIDTH-1:0] rd_val;
  logic [OUT_WIDTH-1:0] drain_word;

  // Shift (optionally rounded) over the full accumulator width.
  function automatic logic [ACC_WIDTH-1:0] shift_full(input logic [ACC_WIDTH-1:0] v,
                                                      input logic [5:0] sh);
    logic [ACC_WIDTH-1:0] t;
    t = v;
`ifdef PSUM_ROUND_EN
    if (sh != 6'd0) t = v + (ACC_WIDTH'(1) << (sh - 6'd1));
`endif
    return ACC_WIDTH'($signed(t) >>> sh);
  endfunction

  // Same as shift_full for one independent half-width lane.
  function automatic logic [AL-1:0] shift_lane(input logic [AL-1:0] v,
                                               input logic [5:0] sh);
    logic [AL-1:0] t;
    t = v;
`ifdef PSUM_ROUND_EN
    if (sh != 6'd0) t = v + (AL'(1) << (sh - 6'd1));
`endif
    return AL'($signed(t) >>> sh);
  endfunction

  // Value fits when every bit above the output sign bit matches the sign.
  function automatic logic [OUT_WIDTH-1:0] sat_full(input logic [ACC_WIDTH-1:0] v);
    logic [OUT_WIDTH-1:0] r;
    if (&v[ACC_WIDTH-1:OUT_WIDTH-1] || ~|v[ACC_WIDTH-1:OUT_WIDTH-1])
      r = v[OUT_WIDTH-1:0];
    else if (v[ACC_WIDTH-1])
      r = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      r = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    return r;
  endfunction

  function automatic logic [OL-1:0] sat_lane(input logic [AL-1:0] v);
    logic [OL-1:0] r;
    if (&v[AL-1:OL-1] || ~|v[AL-1:OL-1])
      r = v[OL-1:0];
    else if (v[AL-1])
      r = {1'b1, {(OL-1){1'b0}}};
    else
      r = {1'b0, {(OL-1){1'b1}}};
    return r;
  endfunction

  always_comb begin
    cfg_num_eff = cfg_num_out;
    if (cfg_num_out == '0)
      cfg_num_eff = (ADDR_W+1)'(1);
    else if (cfg_num_out > (ADDR_W+1)'(DEPTH))
      cfg_num_eff = (ADDR_W+1)'(DEPTH);
    cfg_len_eff = (cfg_acc_len == 16'd0) ? 16'd1 : cfg_acc_len;
  end

  // Out-of-range addresses are dropped without touching the pass count.
  assign beat_ok   = in_valid && (state == S_ACCUM) && ({1'b0, in_addr} < num_out);
  assign pass_end  = beat_ok && ({1'b0, in_addr} == num_out - (ADDR_W+1)'(1));
  assign last_pass = ({1'b0, pass_cnt} + 17'd1) == {1'b0, acc_len};
  assign out_last  = ({1'b0, out_addr} == num_out - (ADDR_W+1)'(1));

  // Read-modify-write operand; lanes add separately so no carry crosses bit AL.
  always_comb begin
    acc_old = acc_mem[in_addr];
    if (mode8) begin
      in_ext  = {{(AL-PL){in_data[PE_OUT_WIDTH-1]}}, in_data[PE_OUT_WIDTH-1:PL],
                 {(AL-PL){in_data[PL-1]}}, in_data[PL-1:0]};
      acc_sum = {acc_old[ACC_WIDTH-1:AL] + in_ext[ACC_WIDTH-1:AL],
                 acc_old[AL-1:0] + in_ext[AL-1:0]};
    end else begin
      in_ext  = {{(ACC_WIDTH-PE_OUT_WIDTH){in_data[PE_OUT_WIDTH-1]}}, in_data};
      acc_sum = acc_old + in_ext;
    end
  end

  assign rd_idx = issue_cnt[ADDR_W-1:0];
  assign rd_val = acc_mem[rd_idx];

  always_comb begin
    if (mode8)
      drain_word = {sat_lane(shift_lane(rd_val[ACC_WIDTH-1:AL], shift)),
                    sat_lane(shift_lane(rd_val[AL-1:0], shift))};
    else
      drain_word = sat_full(shift_full(rd_val, shift));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (cfg_start) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (pass_end && last_pass) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_valid && out_ready && out_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Buffer contents survive reset; the first pass of each job overwrites them.
  always_ff @(posedge clk) begin
    if (!reset && beat_ok)
      acc_mem[in_addr] <= (pass_cnt == 16'd0) ? in_ext : acc_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode8     <= 1'b0;
      num_out   <= (ADDR_W+1)'(1);
      acc_len   <= 16'd1;
      shift     <= 6'd0;
      pass_cnt  <= 16'd0;
      issue_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          out_valid <= 1'b0;
          issue_cnt <= '0;
          if (cfg_start) begin
            mode8    <= choose_8bit;
            num_out  <= cfg_num_eff;
            acc_len  <= cfg_len_eff;
            shift    <= cfg_shift;
            pass_cnt <= 16'd0;
          end
        end
        S_ACCUM: begin
          issue_cnt <= '0;
          if (pass_end) pass_cnt <= pass_cnt + 16'd1;
        end
        S_DRAIN: begin
          // Load the next word when the output register is empty or being taken;
          // otherwise hold it stable under backpressure.
          if (!out_valid || out_ready) begin
            if (issue_cnt < num_out) begin
              out_valid <= 1'b1;
              out_data  <= drain_word;
              out_addr  <= rd_idx;
              issue_cnt <= issue_cnt + (ADDR_W+1)'(1);
            end else begin
              out_valid <= 1'b0;
            end
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_psum_accum.sv
// tb/tb_pe_psum_accum.sv - directed scoreboard bench for pe_psum_accum

module tb_pe_psum_accum;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic        choose_8bit = 1'b0;
  logic [4:0]  cfg_num_out = 5'd0;
  logic [15:0] cfg_acc_len = 16'd0;
  logic [5:0]  cfg_shift = 6'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_data = 48'd0;
  logic [3:0]  in_addr = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_addr;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_exp;

  pe_psum_accum dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .choose_8bit(choose_8bit),
    .cfg_num_out(cfg_num_out), .cfg_acc_len(cfg_acc_len), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted output word is matched against the queue head.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("word", 32'({out_addr, out_data}), 32'(mon_exp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] s48(input int v);
    return 48'(v);
  endfunction

  function automatic logic [47:0] pack8(input int hi, input int lo);
    logic [23:0] h;
    logic [23:0] l;
    h = 24'(hi);
    l = 24'(lo);
    return {h, l};
  endfunction

  task automatic start_job(input logic m8, input int nout, input int alen, input int sh);
    choose_8bit = m8;
    cfg_num_out = 5'(nout);
    cfg_acc_len = 16'(alen);
    cfg_shift   = 6'(sh);
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
  endtask

  task automatic beat(input int addr, input logic [47:0] d);
    in_valid = 1'b1;
    in_addr  = 4'(addr);
    in_data  = d;
    check("in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input int addr, input logic [15:0] d);
    exp_q.push_back({4'(addr), d});
  endtask

  task automatic finish_job(input string tag);
    int  start_cnt;
    bit  seen;
    start_cnt = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    tick();
    check({tag, "_done_single"}, 32'(done), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt - start_cnt), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_all_words"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    tick(); tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // 16-bit accumulation over three passes: 100 - 30 + 5 = 75
    start_job(1'b0, 1, 3, 0);
    expect_word(0, 16'h004B);
    beat(0, s48(100));
    beat(0, s48(-30));
    beat(0, s48(5));
    finish_job("acc16");

    // 8-bit dual lane; addr1 low lane saturates at +127
    start_job(1'b1, 2, 2, 0);
    expect_word(0, 16'hF814);
    expect_word(1, 16'h007F);
    beat(0, pack8(-4, 10));
    beat(1, pack8(0, 200));
    beat(0, pack8(-4, 10));
    beat(1, pack8(0, 200));
    finish_job("lane8");

    // 16-bit saturation both directions
    start_job(1'b0, 2, 1, 0);
    expect_word(0, 16'h7FFF);
    expect_word(1, 16'h8000);
    beat(0, s48(40000));
    beat(1, s48(-40000));
    finish_job("sat16");

    // Shift by one, rounding depends on build option
    start_job(1'b0, 2, 1, 1);
`ifdef PSUM_ROUND_EN
    expect_word(0, 16'h0004);
    expect_word(1, 16'hFFFD);
`else
    expect_word(0, 16'h0003);
    expect_word(1, 16'hFFFC);
`endif
    beat(0, s48(7));
    beat(1, s48(-7));
    finish_job("shift");

    // Backpressure mid-drain: word 1 must hold for five stalled cycles
    start_job(1'b0, 4, 1, 0);
    expect_word(0, 16'h03E8);
    expect_word(1, 16'hF830);
    expect_word(2, 16'h0003);
    expect_word(3, 16'h7FFF);
    beat(0, s48(1000));
    beat(1, s48(-2000));
    beat(2, s48(3));
    beat(3, s48(50000));
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick();
    end
    check("bp_first_valid", 32'(out_valid), 32'd1);
    check("bp_first_addr", 32'(out_addr), 32'd0);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_addr", 32'(out_addr), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'h0000F830);
      tick();
    end
    out_ready = 1'b1;
    finish_job("bp");

    // Reset during accumulation, then a fresh job must not see the stale sum
    start_job(1'b0, 1, 3, 0);
    beat(0, s48(50));
    beat(0, s48(60));
    reset = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    tick();
    start_job(1'b0, 1, 1, 0);
    expect_word(0, 16'h0009);
    beat(0, s48(9));
    finish_job("fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
